high_score_table: RTL and testbench

//  Top-DEPTH leaderboard that replaces the single-register highest-score tracker.
//  On each entry into the FINISH game mode, the round's final score is inserted

---
 rtl/high_score_table.sv | 177 +++++++++++++++++
 tb/tb_high_score_table.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/high_score_table.sv
// Top-DEPTH descending leaderboard. Each entry into FINISH mode inserts the
// round score with a one-compare-per-cycle scan from the bottom entry upward.
module high_score_table #(
  parameter int         SCORE_W     = 8,
  parameter int         DEPTH       = 4,
  parameter logic [2:0] FINISH_MODE = 3'b101,
  localparam int        IDX_W       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               tb_n_rst,
  input  logic               clear,
  input  logic [SCORE_W-1:0] score,
  input  logic [2:0]         mode,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [SCORE_W-1:0] rd_score,
  output logic [SCORE_W-1:0] highest_score,
  output logic [IDX_W-1:0]   rank,
  output logic               new_high,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] RANK_NONE = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [2:0]         prev_mode_r;
  logic               start_s;
  logic [1:0]         state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [SCORE_W-1:0] cand_r, cand_s;
  logic [IDX_W-1:0]   rank_r, rank_s;
  logic [SCORE_W-1:0] table_r [DEPTH];
  logic [SCORE_W-1:0] table_s [DEPTH];
  logic               done_r, done_s;
  logic               new_high_r, new_high_s;
  logic               busy_r, busy_s;
  logic [SCORE_W-1:0] cur_s;
  logic [SCORE_W-1:0] rd_score_s;

  assign start_s = (mode == FINISH_MODE) && (prev_mode_r != FINISH_MODE);

  // Entry currently under comparison, table[idx]
  always_comb begin
    cur_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cur_s = (idx_r == IDX_W'(i)) ? table_r[i] : cur_s;
    end
  end

  // Display read port; out-of-range indices read as zero
  always_comb begin
    rd_score_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_score_s = (rd_idx == IDX_W'(i)) ? table_r[i] : rd_score_s;
    end
  end

  // Insertion FSM next-state and table update
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cand_s     = cand_r;
    rank_s     = rank_r;
    table_s    = table_r;
    done_s     = 1'b0;
    new_high_s = 1'b0;
    busy_s     = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_s[i] = '0;
      end
      rank_s  = RANK_NONE;
      state_s = ST_IDLE;
      idx_s   = LAST_IDX;
      cand_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            cand_s  = score;
            idx_s   = LAST_IDX;
            state_s = ST_SCAN;
            busy_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (cand_r > cur_s) begin
            // Candidate outranks this entry: push the entry one slot down
            for (int i = 1; i < DEPTH; i++) begin
              if ((idx_r + IDX_ONE) == IDX_W'(i)) begin
                table_s[i] = cur_s;
              end else begin
                table_s[i] = table_r[i];
              end
            end
            if (idx_r == '0) begin
              table_s[0] = cand_r;
              rank_s     = '0;
              state_s    = ST_DONE;
              done_s     = 1'b1;
              new_high_s = 1'b1;
            end else begin
              idx_s  = idx_r - IDX_ONE;
              busy_s = 1'b1;
            end
          end else begin
            // Ties stop here, so the older equal score stays above
            if (idx_r == LAST_IDX) begin
              rank_s = RANK_NONE;
            end else begin
              rank_s = idx_r + IDX_ONE;
              for (int i = 1; i < DEPTH; i++) begin
                if ((idx_r + IDX_ONE) == IDX_W'(i)) begin
                  table_s[i] = cand_r;
                end else begin
                  table_s[i] = table_r[i];
                end
              end
            end
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      prev_mode_r <= 3'b000;
      state_r     <= ST_IDLE;
      idx_r       <= LAST_IDX;
      cand_r      <= '0;
      rank_r      <= RANK_NONE;
      done_r      <= 1'b0;
      new_high_r  <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= '0;
      end
    end else begin
      prev_mode_r <= mode;
      state_r     <= state_s;
      idx_r       <= idx_s;
      cand_r      <= cand_s;
      rank_r      <= rank_s;
      done_r      <= done_s;
      new_high_r  <= new_high_s;
      busy_r      <= busy_s;
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= table_s[i];
      end
    end
  end

  assign rd_score      = rd_score_s;
  assign highest_score = table_r[0];
  assign rank          = rank_r;
  assign new_high      = new_high_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_high_score_table.sv
// Directed bench for high_score_table: a counting-based leaderboard model feeds
// a scoreboard queue that is popped and compared on each done pulse.
module tb_high_score_table;

  localparam int         SW  = 8;
  localparam int         D   = 4;
  localparam int         IW  = 3;
  localparam logic [2:0] FIN = 3'b101;

  logic          clk = 1'b0;
  logic          tb_n_rst;
  logic          clear;
  logic [SW-1:0] score;
  logic [2:0]    mode;
  logic [IW-1:0] rd_idx;
  logic [SW-1:0] rd_score;
  logic [SW-1:0] highest_score;
  logic [IW-1:0] rank;
  logic          new_high;
  logic          busy;
  logic          done;

  typedef struct {
    logic [IW-1:0]         rank;
    logic                  nh;
    int                    lat;
    logic [D-1:0][SW-1:0]  tbl;
  } exp_t;

  exp_t          sb_q [$];
  logic [SW-1:0] model [D];
  int            passed = 0;
  int            total  = 0;
  int            fails  = 0;

  high_score_table #(.SCORE_W(SW), .DEPTH(D), .FINISH_MODE(FIN)) dut (
    .clk           (clk),
    .tb_n_rst      (tb_n_rst),
    .clear         (clear),
    .score         (score),
    .mode          (mode),
    .rd_idx        (rd_idx),
    .rd_score      (rd_score),
    .highest_score (highest_score),
    .rank          (rank),
    .new_high      (new_high),
    .busy          (busy),
    .done          (done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    fails++;
    $error("FAIL %s observed=missing expected=present", tag);
  endtask

  // Rank = number of stored entries >= score (older ties stay above)
  function automatic void model_push(input logic [SW-1:0] s);
    exp_t e;
    int   r = 0;
    for (int i = 0; i < D; i++) if (model[i] >= s) r++;
    if (r < D) begin
      for (int i = D - 1; i > r; i--) model[i] = model[i-1];
      model[r] = s;
    end
    e.rank = IW'(r);
    e.nh   = (r == 0);
    e.lat  = (r == D) ? 2 : ((r == 0) ? D + 1 : D - r + 2);
    for (int i = 0; i < D; i++) e.tbl[i] = model[i];
    sb_q.push_back(e);
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < D; i++) model[i] = '0;
  endfunction

  task automatic check_table(input string tag, input logic [D-1:0][SW-1:0] tbl);
    for (int i = 0; i <= D; i++) begin
      rd_idx = IW'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_score), (i < D) ? 32'(tbl[i]) : 32'd0);
    end
  endtask

  task automatic run_round(input string tag, input logic [SW-1:0] s, input bit toggle);
    exp_t e;
    int   dcnt = 0;
    int   ncnt = 0;
    bit   got  = 1'b0;
    @(negedge clk);
    mode = 3'b000;
    @(negedge clk);
    score = s;
    mode  = FIN;
    model_push(s);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (new_high) ncnt++;
      if (done) begin
        dcnt++;
        if (!got) begin
          got = 1'b1;
          if (sb_q.size() == 0) begin
            fail_now({tag, "_scoreboard"});
          end else begin
            e = sb_q.pop_front();
            chk({tag, "_latency"}, 32'(k), 32'(e.lat));
            chk({tag, "_rank"}, 32'(rank), 32'(e.rank));
            chk({tag, "_new_high"}, 32'(new_high), 32'(e.nh));
            chk({tag, "_highest"}, 32'(highest_score), 32'(e.tbl[0]));
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
          end
        end
      end
      if (toggle && k == 1) mode = 3'b000;
      else if (toggle && k == 2) mode = FIN;
    end
    if (!got) begin
      fail_now({tag, "_done_timeout"});
      void'(sb_q.pop_front());
    end else begin
      chk({tag, "_done_count"}, 32'(dcnt), 32'd1);
      chk({tag, "_nh_count"}, 32'(ncnt), 32'(e.nh));
      check_table(tag, e.tbl);
    end
  endtask

  task automatic run_abort(input string tag, input logic [SW-1:0] s, input bit use_reset);
    int dcnt = 0;
    int ncnt = 0;
    @(negedge clk);
    mode = 3'b000;
    @(negedge clk);
    score = s;
    mode  = FIN;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
    if (!use_reset) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end else begin
      #2;
      tb_n_rst = 1'b0;
      mode     = 3'b000;
      #1;
      chk({tag, "_busy_in_rst"}, 32'(busy), 32'd0);
      chk({tag, "_highest_in_rst"}, 32'(highest_score), 32'd0);
      @(negedge clk);
      tb_n_rst = 1'b1;
    end
    model_zero();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (new_high) ncnt++;
    end
    chk({tag, "_done_count"}, 32'(dcnt), 32'd0);
    chk({tag, "_nh_count"}, 32'(ncnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rank"}, 32'(rank), 32'(D));
    check_table(tag, '0);
  endtask

  initial begin
    tb_n_rst = 1'b0;
    clear    = 1'b0;
    score    = '0;
    mode     = 3'b000;
    rd_idx   = '0;
    model_zero();
    repeat (3) @(negedge clk);
    tb_n_rst = 1'b1;
    @(negedge clk);
    chk("rst_highest", 32'(highest_score), 32'd0);
    chk("rst_rank", 32'(rank), 32'(D));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_new_high", 32'(new_high), 32'd0);
    check_table("rst", '0);

    run_round("s50", 8'd50, 1'b0);
    run_round("s30a", 8'd30, 1'b0);
    run_round("s70", 8'd70, 1'b0);
    run_round("s30b", 8'd30, 1'b0);
    run_round("s30full", 8'd30, 1'b0);
    run_round("s80tog", 8'd80, 1'b1);
    run_abort("clr", 8'd90, 1'b0);
    run_round("s0", 8'd0, 1'b0);
    run_round("s40", 8'd40, 1'b0);
    run_abort("arst", 8'd90, 1'b1);
    run_round("s20", 8'd20, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
